// File: rtl/complex_accumulator_if.sv
// complex_accumulator_if: product-in / sum-out stream bundle for complex_accumulator.
//   in_val    : product beat valid (master -> slave)
//   in_ready  : accumulator can take a beat (slave -> master)
//   in_data   : {re, im} product, each 2*DATA_WIDTH bits, two's complement
//   out_val   : sum valid (slave -> master)
//   out_ready : consumer takes the sum (master -> slave)
//   out_data  : {re, im} sum, each ACC_W bits, two's complement
interface complex_accumulator_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned GUARD_BITS = 2
);
    localparam int unsigned ACC_W = 2 * DATA_WIDTH + GUARD_BITS;

    logic                    in_val;
    logic                    in_ready;
    logic [4*DATA_WIDTH-1:0] in_data;
    logic                    out_val;
    logic                    out_ready;
    logic [2*ACC_W-1:0]      out_data;

    modport master (
        output in_val, in_data, out_ready,
        input  in_ready, out_val, out_data
    );

    modport slave (
        input  in_val, in_data, out_ready,
        output in_ready, out_val, out_data
    );
endinterface

// File: rtl/complex_accumulator.sv
// complex_accumulator: sums ACC_LEN consecutive complex products into a widened
// accumulator and presents each sum on a valid/ready output.
//   clk    : clock, rising edge
//   sw_rst : synchronous active-high reset, overrides all activity
//   bus    : complex_accumulator_if.slave (in_val/in_ready/in_data, out_val/out_ready/out_data)
module complex_accumulator #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_LEN    = 4,
    parameter int unsigned GUARD_BITS = 2
) (
    input  logic                   clk,
    input  logic                   sw_rst,
    complex_accumulator_if.slave   bus
);
    localparam int unsigned PW    = 2 * DATA_WIDTH;
    localparam int unsigned ACC_W = PW + GUARD_BITS;
    // Keep the counter at least one bit wide so ACC_LEN = 1 still elaborates.
    localparam int unsigned CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    typedef enum logic {StAccum, StOutput} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_re_q, acc_re_d;
    logic [ACC_W-1:0]   acc_im_q, acc_im_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_val_q, out_val_d;
    logic [2*ACC_W-1:0] out_data_q, out_data_d;

    logic signed [PW-1:0]    in_re, in_im;
    logic signed [ACC_W-1:0] ext_re, ext_im;
    logic [ACC_W-1:0]        sum_re, sum_im;
    logic                    in_ready;
    logic                    beat;

    assign in_re  = bus.in_data[2*PW-1:PW];
    assign in_im  = bus.in_data[PW-1:0];
    // Size cast of a signed operand sign-extends.
    assign ext_re = ACC_W'(in_re);
    assign ext_im = ACC_W'(in_im);
    // Wraps modulo 2^ACC_W by construction.
    assign sum_re = acc_re_q + ext_re;
    assign sum_im = acc_im_q + ext_im;

    // Depends only on registered state and reset, never on in_val or out_ready.
    assign in_ready = (state_q == StAccum) && !sw_rst;
    assign beat     = bus.in_val && in_ready;

    assign bus.in_ready = in_ready;
    assign bus.out_val  = out_val_q;
    assign bus.out_data = out_data_q;

    always_comb begin
        state_d    = state_q;
        acc_re_d   = acc_re_q;
        acc_im_d   = acc_im_q;
        cnt_d      = cnt_q;
        out_val_d  = out_val_q;
        out_data_d = out_data_q;
        unique case (state_q)
            StAccum: begin
                if (beat) begin
                    if (cnt_q == CNT_LAST) begin
                        out_data_d = {sum_re, sum_im};
                        out_val_d  = 1'b1;
                        acc_re_d   = '0;
                        acc_im_d   = '0;
                        cnt_d      = '0;
                        state_d    = StOutput;
                    end else begin
                        acc_re_d = sum_re;
                        acc_im_d = sum_im;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
            end
            StOutput: begin
                if (out_val_q && bus.out_ready) begin
                    out_val_d = 1'b0;
                    state_d   = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            state_q    <= StAccum;
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            cnt_q      <= '0;
            out_val_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_re_q   <= acc_re_d;
            acc_im_q   <= acc_im_d;
            cnt_q      <= cnt_d;
            out_val_q  <= out_val_d;
            out_data_q <= out_data_d;
        end
    end
endmodule

// File: tb/tb_complex_accumulator.sv
// tb_complex_accumulator: directed and random stimulus against a queue-based
// reference model of the complex accumulator (DW=8, ACC_LEN=4, GUARD_BITS=2).
module tb_complex_accumulator;
    localparam int unsigned DW    = 8;
    localparam int unsigned LEN   = 4;
    localparam int unsigned GB    = 2;
    localparam int unsigned ACC_W = 2 * DW + GB;

    logic clk;
    logic sw_rst;

    complex_accumulator_if #(.DATA_WIDTH(DW), .GUARD_BITS(GB)) bus ();

    complex_accumulator #(
        .DATA_WIDTH(DW),
        .ACC_LEN   (LEN),
        .GUARD_BITS(GB)
    ) dut (
        .clk   (clk),
        .sw_rst(sw_rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: partial sum of accepted beats and queue of pending sums.
    logic [2*ACC_W-1:0] exp_q[$];
    int                 part_re, part_im, part_n;
    logic [2*ACC_W-1:0] last_sum;
    int                 out_count;
    int                 accepted;
    int                 low_cycles;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        part_re = 0;
        part_im = 0;
        part_n  = 0;
    endtask

    // One clock cycle: drive, check at negedge, update model, advance past posedge.
    task automatic tick(input logic rst, input logic v, input logic [15:0] re,
                        input logic [15:0] im, input logic ordy);
        bit ready_m;
        bit oval_m;
        sw_rst        = rst;
        bus.in_val    = v;
        bus.in_data   = {re, im};
        bus.out_ready = ordy;
        @(negedge clk);
        if (rst) begin
            chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        end else begin
            ready_m = (exp_q.size() == 0);
            oval_m  = (exp_q.size() != 0);
            chk("in_ready", 64'(bus.in_ready), 64'(ready_m));
            chk("out_val", 64'(bus.out_val), 64'(oval_m));
            if (!bus.in_ready) low_cycles++;
            if (oval_m) begin
                chk("out_data", 64'(bus.out_data), 64'(exp_q[0]));
                if (ordy) begin
                    last_sum = exp_q.pop_front();
                    out_count++;
                end
            end
            if (v && ready_m) begin
                accepted++;
                part_re += int'($signed(re));
                part_im += int'($signed(im));
                part_n++;
                if (part_n == LEN) begin
                    exp_q.push_back({ACC_W'(part_re), ACC_W'(part_im)});
                    part_re = 0;
                    part_im = 0;
                    part_n  = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_clear();
            chk("rst_out_val", 64'(bus.out_val), 64'd0);
            chk("rst_out_data", 64'(bus.out_data), 64'd0);
        end
    endtask

    initial begin
        logic        cur_v;
        logic [15:0] cur_re, cur_im;
        int          acc_before;
        int          rand_start_acc;
        int          rand_start_out;
        int          cyc;

        model_clear();
        out_count     = 0;
        accepted      = 0;
        last_sum      = '0;
        sw_rst        = 1'b1;
        bus.in_val    = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset for two cycles, then in_ready must be 1 immediately.
        tick(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
        tick(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
        tick(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);

        // Basic sum: 4 x (3, 4) back-to-back with out_ready high.
        low_cycles = 0;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 16'd3, 16'd4, 1'b1);
        tick(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
        tick(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
        chk("basic_sum", 64'(last_sum), 64'({18'd12, 18'd16}));
        chk("basic_ready_low", 64'(low_cycles), 64'd1);

        // Sign extension: re = -1, im = 0x7FFF.
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 16'hFFFF, 16'h7FFF, 1'b1);
        tick(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
        chk("sign_ext_sum", 64'(last_sum), 64'({18'h3FFFC, 18'h1FFFC}));

        // Gaps and backpressure: beats 1..4 with 2-cycle gaps, consumer stalled.
        for (int i = 1; i <= 4; i++) begin
            tick(1'b0, 1'b1, 16'(i), 16'(i), 1'b0);
            tick(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
            tick(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        end
        acc_before = accepted;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 16'd7, 16'd7, 1'b0);
        tick(1'b0, 1'b1, 16'd7, 16'd7, 1'b1);
        chk("stall_sum", 64'(last_sum), 64'({18'd10, 18'd10}));
        tick(1'b0, 1'b1, 16'd7, 16'd7, 1'b1);
        chk("stall_beat_taken_once", 64'(accepted - acc_before), 64'd1);
        tick(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);

        // Reset mid-accumulation discards the partial sum.
        tick(1'b0, 1'b1, 16'd5, 16'd5, 1'b1);
        tick(1'b0, 1'b1, 16'd5, 16'd5, 1'b1);
        tick(1'b1, 1'b0, 16'd0, 16'd0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 16'd1, 16'd1, 1'b1);
        tick(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
        chk("reset_mid_sum", 64'(last_sum), 64'({18'd4, 18'd4}));

        // Random stream: 1000 accepted products, random valid/ready, beats held when stalled.
        rand_start_acc = accepted;
        rand_start_out = out_count;
        cur_v  = 1'b1;
        cur_re = 16'($urandom);
        cur_im = 16'($urandom);
        cyc    = 0;
        while ((accepted - rand_start_acc) < 1000 && cyc < 20000) begin
            acc_before = accepted;
            tick(1'b0, cur_v, cur_re, cur_im, 1'($urandom_range(0, 1)));
            cyc++;
            if (!cur_v || accepted != acc_before) begin
                cur_v  = ($urandom_range(0, 3) != 0);
                cur_re = 16'($urandom);
                cur_im = 16'($urandom);
            end
        end
        chk("rand_all_accepted", 64'(accepted - rand_start_acc), 64'd1000);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
        chk("rand_output_count", 64'(out_count - rand_start_out), 64'd250);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
